fifo_axis2native_nbit_adapter: RTL

FIFO_AXIS2NATIVE_NBIT_ADAPTER -- requirements
Module: fifo_axis2native_nbit_adapter

---
 rtl/fifo_axis2native_nbit_adapter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_axis2native_nbit_adapter.sv
// ---------------------------------------------------------------------------
// fifo_axis2native_nbit_adapter
//
// Bridges an AXI-Stream slave port onto the write side of a native FIFO.
// Incoming beats land in a small circular buffer. They are popped whenever
// the downstream FIFO is not programmably full, and then pass through
// DIN_PIPE_NUMBER register stages before reaching the FIFO write port.
// Because of these stages, the FIFO's prog_full threshold must leave room
// for the beats that are still in flight.
//
// Parameters
//   DATA_WIDTH      AXIS payload width
//   DIN_PIPE_NUMBER register stages between buffer pop and FIFO write (1..4)
//   BUF_DEPTH       buffer entries (power of two, >= 2)
//
// Ports
//   s_clk, s_rst          clock, asynchronous active-high reset
//   s_valid/s_ready       AXIS handshake
//   s_data, s_last        AXIS payload and end-of-packet
//   fifo_wren, fifo_din   native FIFO write port, din = {last, data}
//   fifo_prog_full        stops new pops from the buffer
//   fifo_full             native FIFO full, used only by the overflow check
//   wr_overflow           sticky: a write was issued while the FIFO was full
//
// Optional feature macro: AXIS2NATIVE_OVERFLOW_CHK_EN
//   When it is defined, the sticky overflow detector is built.
//   When it is undefined, wr_overflow is tied to 0.
// ---------------------------------------------------------------------------
module fifo_axis2native_nbit_adapter #(
  parameter int DATA_WIDTH      = 32,
  parameter int DIN_PIPE_NUMBER = 1,
  parameter int BUF_DEPTH       = 8
) (
  input  logic                  s_clk,
  input  logic                  s_rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  fifo_wren,
  output logic [DATA_WIDTH:0]   fifo_din,
  input  logic                  fifo_prog_full,
  input  logic                  fifo_full,
  output logic                  wr_overflow
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [DATA_WIDTH:0]        mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_r;
  logic [PTR_W-1:0]           rd_ptr_r;
  logic [CNT_W-1:0]           count_r;
  logic                       push_s;
  logic                       pop_s;
  logic [DIN_PIPE_NUMBER-1:0] pipe_valid_r;
  logic [DATA_WIDTH:0]        pipe_data_r [DIN_PIPE_NUMBER];

  // Ready depends only on the registered occupancy. A pop in the same cycle
  // does not free a slot until the next cycle, so there is no
  // s_valid -> s_ready path and no fifo_prog_full -> s_ready path.
  assign s_ready = (count_r < DEPTH_C);

  // Handshake decode for the buffer push and pop
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (s_valid && s_ready) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if ((count_r != {CNT_W{1'b0}}) && !fifo_prog_full) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Buffer storage. It is deliberately not reset; it is only read behind count_r.
  always_ff @(posedge s_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_last, s_data};
    end
  end

  // Pointers and occupancy. The pointers wrap naturally because BUF_DEPTH is a power of two.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output pipeline. Stage 0 takes the popped entry and each later stage
  // takes the previous one. A stage's data is held when nothing advances into it.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      pipe_valid_r <= {DIN_PIPE_NUMBER{1'b0}};
      for (int i = 0; i < DIN_PIPE_NUMBER; i++) begin
        pipe_data_r[i] <= {(DATA_WIDTH+1){1'b0}};
      end
    end else begin
      pipe_valid_r[0] <= pop_s;
      if (pop_s) begin
        pipe_data_r[0] <= mem_r[rd_ptr_r];
      end
      for (int i = 1; i < DIN_PIPE_NUMBER; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        if (pipe_valid_r[i-1]) begin
          pipe_data_r[i] <= pipe_data_r[i-1];
        end
      end
    end
  end

  assign fifo_wren = pipe_valid_r[DIN_PIPE_NUMBER-1];
  assign fifo_din  = pipe_data_r[DIN_PIPE_NUMBER-1];

`ifdef AXIS2NATIVE_OVERFLOW_CHK_EN
  logic overflow_r;

  // Sticky flag: it sets on any write issued into a full FIFO and clears only on reset.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      overflow_r <= 1'b0;
    end else if (fifo_wren && fifo_full) begin
      overflow_r <= 1'b1;
    end
  end

  assign wr_overflow = overflow_r;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign wr_overflow      = 1'b0;
`endif

endmodule
